quad_decoder: RTL

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/qdec_pkg.sv | 38 +++
 rtl/qdec_sync_filt.sv | 78 +++++++
 rtl/quad_decoder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/qdec_pkg.sv
// ============================================================================
// Module  : qdec_pkg
// Brief   : Shared FSM encoding, Gray positions and step helper for quad_decoder
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package qdec_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } qdec_state_e;

    localparam logic [1:0] C_POS_00 = 2'b00;
    localparam logic [1:0] C_POS_01 = 2'b01;
    localparam logic [1:0] C_POS_11 = 2'b11;
    localparam logic [1:0] C_POS_10 = 2'b10;

    // INIT is left on the edge where the counter has reached this value (3 cycles)
    localparam logic [1:0] C_INIT_LAST = 2'd2;

    function automatic logic [1:0] fwd_next(input logic [1:0] pos);
        logic [1:0] nxt;
        nxt = C_POS_00;
        case (pos)
            C_POS_00: nxt = C_POS_01;
            C_POS_01: nxt = C_POS_11;
            C_POS_11: nxt = C_POS_10;
            C_POS_10: nxt = C_POS_00;
            default:  nxt = C_POS_00;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qdec_sync_filt.sv
// ============================================================================
// Module  : qdec_sync_filt
// Brief   : 2-flop synchronizer plus optional glitch filter (QDEC_FILTER_EN)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module qdec_sync_filt
`ifdef QDEC_FILTER_EN
#(
    parameter int unsigned FILT_CYC = 4
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
`ifdef QDEC_FILTER_EN
    input  logic i_load,
`endif
    output logic o_level
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], i_async};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef QDEC_FILTER_EN
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       filt_q;
    logic       filt_d;

    // While loading, the filter tracks the synchronized level so the decoder
    // starts from the real pin position instead of the reset value.
    always_comb begin
        cnt_d  = 4'd0;
        filt_d = filt_q;
        if (i_load) begin
            filt_d = sync_q[1];
        end else if (sync_q[1] != filt_q) begin
            if (cnt_q == 4'(FILT_CYC - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign o_level = i_load ? sync_q[1] : filt_q;
`else
    assign o_level = sync_q[1];
`endif

endmodule

`default_nettype wire

// File: rtl/quad_decoder.sv
// ============================================================================
// Module  : quad_decoder
// Brief   : Quadrature decoder producing STEP/DIR pulses and a sticky ERR flag;
//           define QDEC_FILTER_EN to add a FILT_CYC-sample input filter
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module quad_decoder
    import qdec_pkg::*;
#(
    parameter int unsigned FILT_CYC = 4
)
(
    input  logic CLK,
    input  logic RST,
    input  logic A,
    input  logic B,
    input  logic CLR_ERR,
    output logic STEP,
    output logic DIR,
    output logic ERR
);

    qdec_state_e state_q;
    qdec_state_e state_d;
    logic [1:0]  init_cnt_q;
    logic [1:0]  init_cnt_d;
    logic [1:0]  prev_q;
    logic [1:0]  prev_d;
    logic        step_q;
    logic        step_d;
    logic        dir_q;
    logic        dir_d;
    logic        err_q;
    logic        err_d;

    logic [1:0]  w_pins;
    logic [1:0]  w_cur;

    assign w_pins = {A, B};

`ifdef QDEC_FILTER_EN
    logic w_load;
    assign w_load = (state_q == ST_INIT);
`endif

    for (genvar i = 0; i < 2; i++) begin : g_chan
        qdec_sync_filt
`ifdef QDEC_FILTER_EN
        #(
            .FILT_CYC (FILT_CYC)
        )
`endif
        u_sync_filt (
            .clk     (CLK),
            .rst_n   (RST),
            .i_async (w_pins[i]),
`ifdef QDEC_FILTER_EN
            .i_load  (w_load),
`endif
            .o_level (w_cur[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = CLR_ERR ? 1'b0 : err_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == C_INIT_LAST) begin
                    prev_d  = w_cur;
                    state_d = ST_TRACK;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            ST_TRACK: begin
                prev_d = w_cur;
                if (w_cur == fwd_next(prev_q)) begin
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                end else if (prev_q == fwd_next(w_cur)) begin
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                end else if (w_cur != prev_q) begin
                    // both bits moved: position lost, set wins over CLR_ERR
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 2'd0;
            prev_q     <= C_POS_00;
            step_q     <= 1'b0;
            dir_q      <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= prev_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign STEP = step_q;
    assign DIR  = dir_q;
    assign ERR  = err_q;

endmodule

`default_nettype wire
